// File: rtl/rmem_stream_ctrl.sv
// -----------------------------------------------------------------------------
// rmem_stream_ctrl
//
// Turns one configured request (base byte address, word count) into a series
// of single-word start/done transactions on the memory read stage. Words that
// come back are buffered in a small FIFO. The FIFO is presented to a downstream
// consumer over a valid/ready stream. At most one read is in flight at a time.
// A read is only started when a FIFO slot is free for its result, so the FIFO
// can never overflow.
//
// Ports
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   cfg_start_i      request strobe, taken only while busy_o = 0
//   cfg_base_addr_i  byte address of the first word
//   cfg_len_i        number of 32-bit words to read (0 = empty request)
//   abort_i          terminate the current request
//   busy_o           high from acceptance through the done_o cycle
//   done_o           one-cycle completion pulse (normal or aborted)
//   rd_start_o       one-cycle start pulse to the read stage
//   rd_addr_o        read address, stable from rd_start_o until rd_done_i
//   rd_done_i        read stage completion pulse
//   rd_rdata_i       read data, valid with rd_done_i
//   out_valid_o      FIFO not empty
//   out_data_o       FIFO head (0 while empty)
//   out_ready_i      consumer takes the head when out_valid_o & out_ready_i
// -----------------------------------------------------------------------------
module rmem_stream_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_start_i,
    input  logic [31:0]      cfg_base_addr_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_start_o,
    output logic [31:0]      rd_addr_o,
    input  logic             rd_done_i,
    input  logic [31:0]      rd_rdata_i,
    output logic             out_valid_o,
    output logic [31:0]      out_data_o,
    input  logic             out_ready_i
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    // Request context. addr_reg always equals base + 4*index, kept as a
    // running sum so the read address needs no multiplier.
    logic [31:0]      addr_reg, addr_next;
    logic [LEN_W-1:0] len_reg, len_next;
    logic [LEN_W-1:0] index_reg, index_next;
    logic             discard_reg, discard_next;
    logic             stall_reg, stall_next;

    // Output FIFO
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_after;
    logic             push, pop, flush;
    logic             room_after;

    // A read is outstanding in WAIT unless we are only parked there waiting
    // for a FIFO slot; only then does rd_done_i carry a real result.
    logic             wait_outstanding;

    assign wait_outstanding = (state_reg == S_WAIT) && !stall_reg;
    assign push = wait_outstanding && rd_done_i && !discard_reg && !abort_i;
    assign pop  = out_valid_o && out_ready_i;

    // Occupancy at the end of this cycle; drives issue/stall/drain decisions.
    always_comb begin
        count_after = count_reg;
        if (push && !pop) begin
            count_after = count_reg + CNT_W'(1);
        end else if (!push && pop) begin
            count_after = count_reg - CNT_W'(1);
        end
    end

    assign room_after = (count_after < DEPTH_C);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_reg    <= 32'h0;
            len_reg     <= '0;
            index_reg   <= '0;
            discard_reg <= 1'b0;
            stall_reg   <= 1'b0;
        end else begin
            addr_reg    <= addr_next;
            len_reg     <= len_next;
            index_reg   <= index_next;
            discard_reg <= discard_next;
            stall_reg   <= stall_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        len_next     = len_reg;
        index_next   = index_reg;
        discard_next = discard_reg;
        stall_next   = stall_reg;
        flush        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (cfg_start_i) begin
                    addr_next    = cfg_base_addr_i;
                    len_next     = cfg_len_i;
                    index_next   = '0;
                    discard_next = 1'b0;
                    stall_next   = 1'b0;
                    state_next   = (cfg_len_i != '0) ? S_ISSUE : S_DONE;
                end
            end

            S_ISSUE: begin
                if (abort_i) begin
                    flush      = 1'b1;
                    state_next = S_DONE;
                end else begin
                    stall_next = 1'b0;
                    state_next = S_WAIT;
                end
            end

            S_WAIT: begin
                if (stall_reg) begin
                    // Parked for a free slot, nothing in flight.
                    if (abort_i) begin
                        flush      = 1'b1;
                        state_next = S_DONE;
                    end else if (room_after) begin
                        stall_next = 1'b0;
                        state_next = S_ISSUE;
                    end
                end else if (rd_done_i) begin
                    index_next = index_reg + LEN_W'(1);
                    if (discard_reg || abort_i) begin
                        // Late result of an aborted request is dropped.
                        flush      = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        addr_next = addr_reg + 32'd4;
                        if (index_next == len_reg) begin
                            state_next = S_DRAIN;
                        end else if (room_after) begin
                            state_next = S_ISSUE;
                        end else begin
                            stall_next = 1'b1;
                        end
                    end
                end else if (abort_i) begin
                    // Cannot cancel the read in flight; wait for it and drop it.
                    discard_next = 1'b1;
                end
            end

            S_DRAIN: begin
                if (abort_i) begin
                    flush      = 1'b1;
                    state_next = S_DONE;
                end else if (count_after == '0) begin
                    state_next = S_DONE;
                end
            end

            S_DONE: begin
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy_o     = 1'b1;
        done_o     = 1'b0;
        rd_start_o = 1'b0;
        case (state_reg)
            S_IDLE:  busy_o = 1'b0;
            // An abort in ISSUE suppresses the start so no orphan read can
            // complete into a later request.
            S_ISSUE: rd_start_o = !abort_i;
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign rd_addr_o = addr_reg;

    // ----------------------------------------------------------------- FIFO
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= rd_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_after;
        end
    end

    assign out_valid_o = (count_reg != '0);
    // Head is shown combinationally; forced to 0 while empty so the stream
    // never exposes stale or uninitialised storage.
    assign out_data_o  = out_valid_o ? fifo_mem[rd_ptr_reg] : 32'h0;

endmodule

// File: tb/tb_rmem_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rmem_stream_ctrl
//
// Directed self-checking bench for rmem_stream_ctrl. A behavioural read stage
// answers each rd_start_o after a programmable latency with data derived from
// the address it was given. A negedge monitor logs every start address,
// every accepted output word and every done pulse. Each test compares those
// logs against hand-computed addresses and data.
// -----------------------------------------------------------------------------
module tb_rmem_stream_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cfg_start_i = 1'b0;
    logic [31:0] cfg_base_addr_i = 32'h0;
    logic [15:0] cfg_len_i = 16'h0;
    logic        abort_i = 1'b0;
    logic        busy_o;
    logic        done_o;
    logic        rd_start_o;
    logic [31:0] rd_addr_o;
    logic        rd_done_i = 1'b0;
    logic [31:0] rd_rdata_i = 32'h0;
    logic        out_valid_o;
    logic [31:0] out_data_o;
    logic        out_ready_i = 1'b0;

    rmem_stream_ctrl #(
        .FIFO_DEPTH(4),
        .LEN_W     (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .cfg_start_i    (cfg_start_i),
        .cfg_base_addr_i(cfg_base_addr_i),
        .cfg_len_i      (cfg_len_i),
        .abort_i        (abort_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .rd_start_o     (rd_start_o),
        .rd_addr_o      (rd_addr_o),
        .rd_done_i      (rd_done_i),
        .rd_rdata_i     (rd_rdata_i),
        .out_valid_o    (out_valid_o),
        .out_data_o     (out_data_o),
        .out_ready_i    (out_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Read stage model and monitor state
    int          lat = 2;
    int          countdown = 0;
    int          stray_req = 0;
    int          stray_seen = 0;
    logic [31:0] pend_addr = 32'h0;
    int          start_cnt = 0;
    int          done_cnt = 0;
    logic [31:0] start_addr_q[$];
    logic [31:0] data_q[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hA5C3_0F1E;
    endfunction

    // Inputs to the DUT change on the falling edge here or 1 ns after the
    // rising edge in the tasks, so the DUT always sees stable values.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            countdown  = 0;
            rd_done_i  = 1'b0;
            rd_rdata_i = 32'h0;
        end else begin
            rd_done_i = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    rd_done_i  = 1'b1;
                    rd_rdata_i = word_of(pend_addr);
                end
            end else if (stray_seen != stray_req) begin
                stray_seen = stray_req;
                rd_done_i  = 1'b1;
                rd_rdata_i = 32'hDEAD_BEEF;
            end
            if (rd_start_o) begin
                start_cnt++;
                start_addr_q.push_back(rd_addr_o);
                pend_addr = rd_addr_o;
                countdown = lat;
            end
            if (out_valid_o && out_ready_i) begin
                data_q.push_back(out_data_o);
            end
            if (done_o) begin
                done_cnt++;
            end
        end
    end

    // Drives a one-cycle request; returns 1 ns into the cycle after acceptance.
    task automatic start_req(input logic [31:0] base, input logic [15:0] len);
        @(posedge clk_i);
        #1;
        cfg_base_addr_i = base;
        cfg_len_i       = len;
        cfg_start_i     = 1'b1;
        @(posedge clk_i);
        #1;
        cfg_start_i = 1'b0;
    endtask

    // Returns at the falling edge of the done_o cycle, or ok = 0 on timeout.
    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns at the rising edge that closes the cycle of the n-th new start.
    task automatic wait_starts(input int base_cnt, input int n, input int budget,
                               output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_i);
            if (start_cnt - base_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy_o);
        end
        checks++;
        if (done_o !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b expected 0", done_o);
        end
        checks++;
        if (rd_start_o !== 1'b0) begin
            errors++; $display("FAIL reset_rd_start: got %b expected 0", rd_start_o);
        end
        checks++;
        if (rd_addr_o !== 32'h0) begin
            errors++; $display("FAIL reset_rd_addr: got %h expected 00000000", rd_addr_o);
        end
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid_o);
        end
        checks++;
        if (out_data_o !== 32'h0) begin
            errors++; $display("FAIL reset_out_data: got %h expected 00000000", out_data_o);
        end
        checks++;
        $display("test_reset: outputs idle after reset");
    endtask

    // Runs a complete request with ready held high and checks the address
    // sequence, the delivered data and a single done pulse.
    task automatic run_stream(input string name, input logic [31:0] base,
                              input logic [15:0] len);
        int s0, n0, a0, d0;
        bit ok;
        logic [31:0] exp_addr;
        s0 = start_cnt; n0 = done_cnt; a0 = start_addr_q.size(); d0 = data_q.size();
        lat = 2;
        out_ready_i = 1'b1;
        start_req(base, len);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL %s_busy_on_accept: got %b expected 1", name, busy_o);
        end
        checks++;
        if (rd_start_o !== 1'b1 || rd_addr_o !== base) begin
            errors++;
            $display("FAIL %s_first_issue: got start=%b addr=%h expected start=1 addr=%h",
                     name, rd_start_o, rd_addr_o, base);
        end
        wait_done(200, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL %s_done_timeout: got no done_o expected done_o", name);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL %s_busy_after_done: got %b expected 0", name, busy_o);
        end
        checks++;
        if (start_cnt - s0 !== int'(len)) begin
            errors++;
            $display("FAIL %s_start_count: got %0d expected %0d", name, start_cnt - s0, len);
        end
        checks++;
        if (data_q.size() - d0 !== int'(len)) begin
            errors++;
            $display("FAIL %s_word_count: got %0d expected %0d", name, data_q.size() - d0, len);
        end
        checks++;
        if (done_cnt - n0 !== 1) begin
            errors++; $display("FAIL %s_done_pulses: got %0d expected 1", name, done_cnt - n0);
        end
        for (int i = 0; i < int'(len); i++) begin
            exp_addr = base + 32'(4 * i);
            if (a0 + i < start_addr_q.size()) begin
                checks++;
                if (start_addr_q[a0 + i] !== exp_addr) begin
                    errors++;
                    $display("FAIL %s_addr%0d: got %h expected %h",
                             name, i, start_addr_q[a0 + i], exp_addr);
                end
            end
            if (d0 + i < data_q.size()) begin
                checks++;
                if (data_q[d0 + i] !== word_of(exp_addr)) begin
                    errors++;
                    $display("FAIL %s_data%0d: got %h expected %h",
                             name, i, data_q[d0 + i], word_of(exp_addr));
                end
            end
        end
        $display("%s: base=%h len=%0d words=%0d", name, base, len, data_q.size() - d0);
    endtask

    task automatic test_basic();
        run_stream("basic", 32'h0000_1000, 16'd3);
    endtask

    task automatic test_addr_wrap();
        run_stream("wrap", 32'hFFFF_FFF8, 16'd3);
    endtask

    task automatic test_backpressure();
        int s0, n0, d0;
        bit ok;
        logic [31:0] exp_addr;
        s0 = start_cnt; n0 = done_cnt; d0 = data_q.size();
        lat = 2;
        out_ready_i = 1'b0;
        start_req(32'h0000_2000, 16'd8);
        repeat (60) @(posedge clk_i);
        #1;
        checks++;
        if (start_cnt - s0 !== 4) begin
            errors++; $display("FAIL bp_stall_starts: got %0d expected 4", start_cnt - s0);
        end
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== word_of(32'h0000_2000)) begin
            errors++;
            $display("FAIL bp_head: got valid=%b data=%h expected valid=1 data=%h",
                     out_valid_o, out_data_o, word_of(32'h0000_2000));
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL bp_busy_stalled: got %b expected 1", busy_o);
        end
        out_ready_i = 1'b1;
        wait_done(300, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL bp_done_timeout: got no done_o expected done_o");
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (start_cnt - s0 !== 8) begin
            errors++; $display("FAIL bp_total_starts: got %0d expected 8", start_cnt - s0);
        end
        checks++;
        if (data_q.size() - d0 !== 8) begin
            errors++; $display("FAIL bp_word_count: got %0d expected 8", data_q.size() - d0);
        end
        checks++;
        if (done_cnt - n0 !== 1) begin
            errors++; $display("FAIL bp_done_pulses: got %0d expected 1", done_cnt - n0);
        end
        for (int i = 0; i < 8; i++) begin
            exp_addr = 32'h0000_2000 + 32'(4 * i);
            if (d0 + i < data_q.size()) begin
                checks++;
                if (data_q[d0 + i] !== word_of(exp_addr)) begin
                    errors++;
                    $display("FAIL bp_data%0d: got %h expected %h",
                             i, data_q[d0 + i], word_of(exp_addr));
                end
            end
        end
        $display("test_backpressure: words=%0d", data_q.size() - d0);
    endtask

    task automatic test_len_zero();
        int s0;
        s0 = start_cnt;
        out_ready_i = 1'b1;
        start_req(32'h0000_3000, 16'd0);
        checks++;
        if (done_o !== 1'b1 || rd_start_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL len0_done_cycle: got done=%b start=%b busy=%b expected done=1 start=0 busy=1",
                     done_o, rd_start_o, busy_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL len0_after: got busy=%b done=%b expected busy=0 done=0", busy_o, done_o);
        end
        checks++;
        if (start_cnt - s0 !== 0) begin
            errors++; $display("FAIL len0_no_start: got %0d expected 0", start_cnt - s0);
        end
        $display("test_len_zero: done without reads");
    endtask

    task automatic test_abort();
        int s0, n0, d0;
        bit ok;
        s0 = start_cnt; n0 = done_cnt; d0 = data_q.size();
        lat = 4;
        out_ready_i = 1'b0;
        start_req(32'h0000_4000, 16'd4);
        wait_starts(s0, 2, 100, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL abort_second_start: got no start expected start");
        end
        // Now in WAIT for word 2 with its read outstanding; word 1 is buffered.
        #1;
        checks++;
        if (out_valid_o !== 1'b1) begin
            errors++; $display("FAIL abort_word1_buffered: got %b expected 1", out_valid_o);
        end
        abort_i = 1'b1;
        @(posedge clk_i);
        #1;
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_waits_for_read: got busy=%b done=%b expected busy=1 done=0",
                     busy_o, done_o);
        end
        wait_done(50, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL abort_done_timeout: got no done_o expected done_o");
        end
        checks++;
        if (out_valid_o !== 1'b0) begin
            errors++; $display("FAIL abort_fifo_flushed: got valid=%b expected 0", out_valid_o);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b valid=%b expected busy=0 valid=0",
                     busy_o, out_valid_o);
        end
        checks++;
        if (start_cnt - s0 !== 2) begin
            errors++; $display("FAIL abort_start_count: got %0d expected 2", start_cnt - s0);
        end
        checks++;
        if (done_cnt - n0 !== 1) begin
            errors++; $display("FAIL abort_done_pulses: got %0d expected 1", done_cnt - n0);
        end
        checks++;
        if (data_q.size() - d0 !== 0) begin
            errors++; $display("FAIL abort_no_words: got %0d expected 0", data_q.size() - d0);
        end
        $display("test_abort: aborted after %0d starts", start_cnt - s0);
        run_stream("after_abort", 32'h0000_5000, 16'd2);
    endtask

    task automatic test_reset_mid();
        int s0, n0;
        bit ok;
        s0 = start_cnt; n0 = done_cnt;
        lat = 4;
        out_ready_i = 1'b1;
        start_req(32'h0000_6000, 16'd4);
        wait_starts(s0, 1, 50, ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL rstmid_first_start: got no start expected start");
        end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || rd_start_o !== 1'b0 ||
            rd_addr_o !== 32'h0 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_outputs: got busy=%b done=%b start=%b addr=%h valid=%b expected all 0",
                     busy_o, done_o, rd_start_o, rd_addr_o, out_valid_o);
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        stray_req++;
        repeat (6) @(posedge clk_i);
        #1;
        checks++;
        if (busy_o !== 1'b0 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stray_done: got busy=%b valid=%b expected busy=0 valid=0",
                     busy_o, out_valid_o);
        end
        checks++;
        if (start_cnt - s0 !== 1 || done_cnt - n0 !== 0) begin
            errors++;
            $display("FAIL rstmid_no_activity: got starts=%0d dones=%0d expected starts=1 dones=0",
                     start_cnt - s0, done_cnt - n0);
        end
        $display("test_reset_mid: reset during WAIT");
    endtask

    initial begin
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_len_zero();
        test_abort();
        test_addr_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
